// File: rtl/alu_mc_pkg.sv
// Opcode and state definitions shared by the multi-cycle ALU and its bench.
// The package is named opcodes so the operation-select port type reads opcodes::alu_functions_t.
// Any 3-bit code not listed below is an unknown function: it returns zero with zero=1.
package opcodes;

    // ALU_ADD and ALU_MULT keep their original encodings; the remaining codes are the extensions.
    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_MULT  = 3'd1,
        ALU_SUB   = 3'd2,
        ALU_AND   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_XOR   = 3'd5,
        ALU_PASSB = 3'd6
    } alu_functions_t;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } alu_mc_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock, STEPS clocks per product.
// done is asserted during the last step, and product then shows the final value.
// The parent registers the result on the same edge that the final step completes.
module alu_mul_iter #(
    parameter int W     = 9,
    parameter int STEPS = W
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);
    import opcodes::*;

    localparam int CW = $clog2(STEPS + 1);

    logic [2*W-1:0] acc_reg;
    logic [2*W-1:0] acc_next;
    logic [W-1:0]   mcand_reg;
    logic [W-1:0]   mplier_reg;
    logic [CW-1:0]  count_reg;
    logic           busy_reg;
    logic [W:0]     hi_sum;

    // One step: add the multiplicand into the high half when the multiplier LSB is set,
    // then shift right. The extra sum bit carries into the top of the shifted accumulator.
    always_comb begin
        hi_sum   = {1'b0, acc_reg[2*W-1:W]} + (mplier_reg[0] ? {1'b0, mcand_reg} : {(W+1){1'b0}});
        acc_next = {hi_sum, acc_reg[W-1:1]};
    end

    assign busy    = busy_reg;
    assign done    = busy_reg && (count_reg == CW'(STEPS - 1));
    assign product = acc_next;

    // Accumulator, operand latches and step counter. Reset discards any multiply in flight.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            acc_reg    <= '0;
            mcand_reg  <= a;
            mplier_reg <= b;
            count_reg  <= '0;
            busy_reg   <= 1'b1;
        end else if (busy_reg) begin
            acc_reg    <= acc_next;
            mplier_reg <= {1'b0, mplier_reg[W-1:1]};
            count_reg  <= count_reg + CW'(1);
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both the input and the output side.
// The logic and arithmetic operations take one cycle. MULT takes W cycles through alu_mul_iter.
// Optional macro ALU_SAT_EN: when it is defined, ADD saturates to all-ones on carry-out and
// SUB saturates to zero on borrow. In both cases carry still reports the overflow or borrow.
module alu_mc
    import opcodes::*;
#(
    parameter int n         = 8,
    parameter int MUL_STEPS = n + 1
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [n:0]           a,
    input  logic [n:0]           b,
    input  alu_functions_t       Function,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [n:0]           q,
    output logic [n:0]           qh,
    output logic                 carry,
    output logic                 zero
);
    localparam int W = n + 1;

    alu_mc_state_t  state_reg, state_next;
    logic [W-1:0]   q_reg, qh_reg;
    logic           carry_reg, zero_reg, out_valid_reg;

    logic           accept;
    logic           mul_start, mul_busy, mul_done;
    logic [2*W-1:0] mul_product;

    logic [W:0]     sum, diff;
    logic [W-1:0]   and_v, or_v, xor_v;
    logic [W-1:0]   res_q;
    logic           res_carry;

    // Bitwise operations, built per bit.
    for (genvar gi = 0; gi < W; gi++) begin : g_bitwise
        assign and_v[gi] = a[gi] & b[gi];
        assign or_v[gi]  = a[gi] | b[gi];
        assign xor_v[gi] = a[gi] ^ b[gi];
    end

    // Handshake. in_ready is held low while reset is asserted.
    assign in_ready  = nReset && (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (Function == ALU_MULT);

    alu_mul_iter #(
        .W     (W),
        .STEPS (MUL_STEPS)
    ) u_mul (
        .Clock   (Clock),
        .nReset  (nReset),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // Single-cycle result and carry. Unknown codes, and MULT on this path, give zero.
    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        diff      = {1'b0, a} - {1'b0, b};
        res_q     = '0;
        res_carry = 1'b0;
        case (Function)
            ALU_ADD: begin
                res_q     = sum[W-1:0];
                res_carry = sum[W];
`ifdef ALU_SAT_EN
                if (sum[W]) res_q = '1;
`endif
            end
            ALU_SUB: begin
                res_q     = diff[W-1:0];
                res_carry = diff[W];
`ifdef ALU_SAT_EN
                if (diff[W]) res_q = '0;
`endif
            end
            ALU_AND:   res_q = and_v;
            ALU_OR:    res_q = or_v;
            ALU_XOR:   res_q = xor_v;
            ALU_PASSB: res_q = b;
            default: begin
                res_q     = '0;
                res_carry = 1'b0;
            end
        endcase
    end

    // Next state: IDLE goes to MUL on an accepted multiply, and MUL returns on its final step.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (mul_start) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Result registers. The values hold until they are consumed or replaced. Accepting a multiply
    // drops out_valid, because accepting requires that any previous result is being consumed.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            q_reg         <= '0;
            qh_reg        <= '0;
            carry_reg     <= 1'b0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
        end else if (accept && (Function != ALU_MULT)) begin
            q_reg         <= res_q;
            qh_reg        <= '0;
            carry_reg     <= res_carry;
            zero_reg      <= (res_q == '0);
            out_valid_reg <= 1'b1;
        end else if (mul_done) begin
            q_reg         <= mul_product[W-1:0];
            qh_reg        <= mul_product[2*W-1:W];
            carry_reg     <= |mul_product[2*W-1:W];
            zero_reg      <= (mul_product == '0);
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign q         = q_reg;
    assign qh        = qh_reg;
    assign carry     = carry_reg;
    assign zero      = zero_reg;
    assign out_valid = out_valid_reg;

endmodule
